hex_display_mux: RTL

Parametrised, time-multiplexed driver for a bank of common-anode 7-segment hex digits, for boards that share one segment bus across DIGITS digits. It latches a DIGITS-nibble value on a load strobe and scans one digit per slot. Each slot has a blanking gap to suppress ghosting. Adds optional leading-zero suppression, per-digit decimal points, a global enable and a frame-done pulse. It sits between the core's debug/result registers and the board's segment/anode pins.

---
 rtl/hex_display_pkg.sv | 16 +
 rtl/hex_seg_decode.sv | 11 +
 rtl/hex_display_mux.sv | 138 +++++++++++++
 3 files changed

// File: rtl/hex_display_pkg.sv
// Shared types and constants for the multiplexed hex display driver.
package hex_display_pkg;

  typedef enum logic [1:0] {IDLE, GAP, SHOW} state_e;

  // Active-high {g,f,e,d,c,b,a}; index 15 is leftmost in the packed literal.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input logic active_low);
    return active_low ? ~seg : seg;
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to active-high 7-segment pattern.
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/hex_display_mux.sv
// Time-multiplexed common-anode hex display scanner with blanking gap,
// leading-zero suppression, decimal points and a frame-done pulse.
module hex_display_mux
  import hex_display_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SLOT_CYCLES    = 50000,
  parameter int GAP_CYCLES     = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  lz_blank,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     anodes,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_END = CW'(SLOT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DIGITS-1:0][3:0]  val_q;
  logic [DIGITS-1:0]       dpm_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [DIGITS-1:0]       an_q, an_d;
  logic                    fd_q, fd_d;
  logic [6:0]              dec;
  logic                    blank;
  logic [DIGITS-1:0]       onehot;

  hex_seg_decode u_dec (.nibble_i(val_q[idx_q]), .seg_o(dec));

  // Blank digit idx when it and every more-significant nibble are zero.
  always_comb begin
    blank = 1'b0;
    if (lz_blank && idx_q != '0) begin
      blank = 1'b1;
      for (int i = 0; i < DIGITS; i++)
        if (i >= int'(idx_q) && val_q[i] != 4'h0) blank = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    fd_d    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = GAP;
        GAP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == GAP_END) state_d = SHOW;
        end
        SHOW: begin
          if (cnt_q == SLOT_END) begin
            state_d = GAP;
            cnt_d   = '0;
            idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            fd_d    = (idx_q == LAST_IDX);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Segment/dp captured only on GAP->SHOW so a load never alters a live slot.
  always_comb begin
    onehot = {{(DIGITS-1){1'b0}}, 1'b1} << idx_d;
    an_d   = {DIGITS{AN_INV}};
    seg_d  = seg_polarity(7'h00, SEG_INV);
    dp_d   = SEG_INV;
    if (state_d == SHOW) begin
      an_d = onehot ^ {DIGITS{AN_INV}};
      if (state_q == GAP) begin
        seg_d = seg_polarity(blank ? 7'h00 : dec, SEG_INV);
        dp_d  = SEG_INV ^ dpm_q[idx_q];
      end else begin
        seg_d = seg_q;
        dp_d  = dp_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      dpm_q   <= '0;
      seg_q   <= seg_polarity(7'h00, SEG_INV);
      dp_q    <= SEG_INV;
      an_q    <= {DIGITS{AN_INV}};
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      fd_q    <= fd_d;
      if (load) begin
        val_q <= value;
        dpm_q <= dp_mask;
      end
    end
  end

  assign segments   = seg_q;
  assign dp         = dp_q;
  assign anodes     = an_q;
  assign frame_done = fd_q;

endmodule
